// File: rtl/sift_feat.sv
// sift_feat: streaming 3x3 window feature extractor.
// Reads the image row-major from external memory. It emits the window max/min,
// a local-extremum keypoint flag, gradient magnitude and a 10-degree orientation
// bin for every interior pixel.
// Optional macro SIFT_FEAT_CONTRAST_EN: keypoints also need (max-min) >= CONTRAST_TH.
module sift_feat #(
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int CONTRAST_TH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    output logic [17:0] addr,
    output logic [7:0]  max,
    output logic [7:0]  min,
    output logic        dout_kp,
    output logic [7:0]  mag,
    output logic [5:0]  dir,
    output logic        out_en,
    output logic        complete1,
    output logic        complete2
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [17:0]   LAST_ADDR = 18'(NPIX - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO     = XW'(2);
    localparam logic [YW-1:0] Y_TWO     = YW'(2);
    localparam logic [8:0]    CTH       = 9'(CONTRAST_TH);
`ifdef SIFT_FEAT_CONTRAST_EN
    localparam bit USE_CONTRAST = 1'b1;
`else
    localparam bit USE_CONTRAST = 1'b0;
`endif

    // 256*tan(10*(i+1) degrees), rounded: boundaries between orientation bins
    function automatic logic [10:0] tan_k(input int i);
        case (i)
            0:       tan_k = 11'd45;
            1:       tan_k = 11'd93;
            2:       tan_k = 11'd148;
            3:       tan_k = 11'd215;
            4:       tan_k = 11'd305;
            5:       tan_k = 11'd443;
            6:       tan_k = 11'd703;
            default: tan_k = 11'd1452;
        endcase
    endfunction

    // scan state: address, its x/y split, and the sticky scan-done flag
    logic [17:0]   addr_q, addr_d;
    logic [XW-1:0] ax_q, ax_d;
    logic [YW-1:0] ay_q, ay_d;
    logic          c1_q, c1_d;
    // read stage: din is valid for pixel (px_q, py_q) when rd_v_q is set
    logic          rd_v_q;
    logic [XW-1:0] px_q;
    logic [YW-1:0] py_q;
    // window stage: w_q[row][col], col 2 is the newest column
    logic          wv_q;
    logic [XW-1:0] wx_q;
    logic [YW-1:0] wy_q;
    logic [7:0]    w_q [3][3];
    logic [7:0]    lb1_q [IMG_W];
    logic [7:0]    lb2_q [IMG_W];
    // registered results
    logic [7:0]    max_q, min_q, mag_q;
    logic [5:0]    dir_q;
    logic          kp_q, oe_q, last_q, c2_q;

    // Next read address: walk row-major and stop on the last pixel, flagging it.
    always_comb begin
        addr_d = addr_q;
        ax_d   = ax_q;
        ay_d   = ay_q;
        c1_d   = c1_q;
        if (!c1_q) begin
            if (addr_q == LAST_ADDR) begin
                c1_d = 1'b1;
            end else begin
                addr_d = addr_q + 18'd1;
                if (ax_q == X_LAST) begin
                    ax_d = '0;
                    ay_d = ay_q + YW'(1);
                end else begin
                    ax_d = ax_q + XW'(1);
                end
            end
        end
    end

    // Scan, read-stage and window-stage control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            ax_q   <= '0;
            ay_q   <= '0;
            c1_q   <= 1'b0;
            rd_v_q <= 1'b0;
            px_q   <= '0;
            py_q   <= '0;
            wv_q   <= 1'b0;
            wx_q   <= '0;
            wy_q   <= '0;
        end else begin
            addr_q <= addr_d;
            ax_q   <= ax_d;
            ay_q   <= ay_d;
            c1_q   <= c1_d;
            // a fresh address this cycle means fresh data on din next cycle
            rd_v_q <= !c1_q;
            px_q   <= ax_q;
            py_q   <= ay_q;
            wv_q   <= rd_v_q;
            wx_q   <= px_q;
            wy_q   <= py_q;
        end
    end

    // Line buffers and window shift; contents need no reset because the valid flags gate them.
    always_ff @(posedge clk) begin
        if (rd_v_q) begin
            lb1_q[px_q] <= din;
            lb2_q[px_q] <= lb1_q[px_q];
            for (int r = 0; r < 3; r++) begin
                w_q[r][0] <= w_q[r][1];
                w_q[r][1] <= w_q[r][2];
            end
            w_q[0][2] <= lb2_q[px_q];
            w_q[1][2] <= lb1_q[px_q];
            w_q[2][2] <= din;
        end
    end

    // Window evaluation for centre (wx_q-1, wy_q-1).
    logic       ctr_ok, ctr_last, gt_all, lt_all, kp_c, on_b;
    logic [7:0] mx_c, mn_c, agx, agy, mag_c;
    logic [8:0] gx_c, gy_c, sum9;
    logic [19:0] ay256, prod;
    logic [7:0] ge, eq;
    logic [3:0] bcnt;
    logic [5:0] dir_c;

    // Range, extremum test, gradient and orientation bin of the current window.
    always_comb begin
        ctr_ok   = wv_q && (wx_q >= X_TWO) && (wy_q >= Y_TWO);
        ctr_last = (wx_q == X_LAST) && (wy_q == Y_LAST);
        mx_c     = 8'd0;
        mn_c     = 8'hff;
        gt_all   = 1'b1;
        lt_all   = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (w_q[r][c] > mx_c) mx_c = w_q[r][c];
                if (w_q[r][c] < mn_c) mn_c = w_q[r][c];
                if (!(r == 1 && c == 1)) begin
                    if (w_q[r][c] >= w_q[1][1]) gt_all = 1'b0;
                    if (w_q[r][c] <= w_q[1][1]) lt_all = 1'b0;
                end
            end
        end
        kp_c = (gt_all || lt_all) &&
               (!USE_CONTRAST || ({1'b0, mx_c - mn_c} >= CTH));

        gx_c  = {1'b0, w_q[1][2]} - {1'b0, w_q[1][0]};
        gy_c  = {1'b0, w_q[2][1]} - {1'b0, w_q[0][1]};
        agx   = 8'(gx_c[8] ? -gx_c : gx_c);
        agy   = 8'(gy_c[8] ? -gy_c : gy_c);
        sum9  = {1'b0, agx} + {1'b0, agy};
        mag_c = 8'(sum9 >> 1);

        // fold into the first quadrant: bcnt = boundaries at or below the angle
        ay256 = {4'd0, agy, 8'd0};
        bcnt  = 4'd0;
        ge    = '0;
        eq    = '0;
        prod  = '0;
        for (int i = 0; i < 8; i++) begin
            prod  = 20'(agx) * 20'(tan_k(i));
            ge[i] = (ay256 >= prod);
            eq[i] = (ay256 == prod);
            bcnt  = bcnt + 4'(ge[i]);
        end
        on_b = (bcnt == 4'd0) ? (agy == 8'd0) : eq[3'(bcnt - 4'd1)];

        // unfold by quadrant; exact boundaries belong to the higher bin
        if (gx_c == 9'd0 && gy_c == 9'd0) begin
            dir_c = 6'd0;
        end else if (gx_c == 9'd0) begin
            dir_c = gy_c[8] ? 6'd27 : 6'd9;
        end else if (!gx_c[8] && !gy_c[8]) begin
            dir_c = {2'b00, bcnt};
        end else if (gx_c[8] && !gy_c[8]) begin
            dir_c = on_b ? (6'd18 - {2'b00, bcnt}) : (6'd17 - {2'b00, bcnt});
        end else if (gx_c[8]) begin
            dir_c = 6'd18 + {2'b00, bcnt};
        end else begin
            dir_c = on_b ? (6'd36 - {2'b00, bcnt}) : (6'd35 - {2'b00, bcnt});
        end
    end

    // Output registers: load on an interior centre, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q  <= '0;
            min_q  <= '0;
            kp_q   <= 1'b0;
            mag_q  <= '0;
            dir_q  <= '0;
            oe_q   <= 1'b0;
            last_q <= 1'b0;
            c2_q   <= 1'b0;
        end else begin
            oe_q   <= ctr_ok;
            last_q <= ctr_ok && ctr_last;
            c2_q   <= c2_q || (oe_q && last_q);
            if (ctr_ok) begin
                max_q <= mx_c;
                min_q <= mn_c;
                kp_q  <= kp_c;
                mag_q <= mag_c;
                dir_q <= dir_c;
            end
        end
    end

    assign addr      = addr_q;
    assign max       = max_q;
    assign min       = min_q;
    assign dout_kp   = kp_q;
    assign mag       = mag_q;
    assign dir       = dir_q;
    assign out_en    = oe_q;
    assign complete1 = c1_q;
    assign complete2 = c2_q;

endmodule

// File: tb/tb_sift_feat.sv
// tb_sift_feat: directed images against a pixel-level model of the extractor.
// The expected output stream and its cycle schedule are derived from the image
// and the read timing (address k driven k cycles after reset release, data one
// cycle later, results two cycles after the bottom-right window pixel arrives).
module tb_sift_feat;
  localparam int W      = 8;
  localparam int H      = 8;
  localparam int N      = W * H;
  localparam int CTH    = 200;
  localparam int NPULSE = (W - 2) * (H - 2);
`ifdef SIFT_FEAT_CONTRAST_EN
  localparam bit KP_SINGLE = 1'b0;
`else
  localparam bit KP_SINGLE = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'd0;
  logic [17:0] addr;
  logic [7:0]  max_o, min_o, mag;
  logic        kp, out_en, c1, c2;
  logic [5:0]  dir;

  sift_feat #(.IMG_W(W), .IMG_H(H), .CONTRAST_TH(CTH)) dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr),
    .max(max_o), .min(min_o), .dout_kp(kp), .mag(mag), .dir(dir),
    .out_en(out_en), .complete1(c1), .complete2(c2)
  );

  // clock / reset bookkeeping
  initial forever #5 clk = ~clk;

  logic [7:0]  img [N];
  logic [30:0] exp_q [$];
  logic [30:0] last_v = '0;
  int checks = 0;
  int errors = 0;
  int rel = 0;
  int pulses = 0;
  bit rst_seen = 1'b0;
  bit active = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      rel = 0;
      rst_seen = 1'b1;
      active = 1'b1;
    end else begin
      rel++;
      rst_seen = 1'b0;
    end
  end

  // external memory: din carries the pixel addressed in the previous cycle
  initial begin
    int a_s;
    a_s = 0;
    forever begin
      @(negedge clk);
      a_s = int'(addr);
      if (a_s >= N) a_s = 0;
      @(posedge clk);
      #1 din = img[a_s];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model
  function automatic int pix(int x, int y);
    return int'(img[y * W + x]);
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // angle kept in half-degrees: exact boundary -> 20*b, strictly inside -> 20*b+10
  function automatic int model_dir(int gx, int gy);
    int k_tab [8];
    int ax, ay, b, a2, full;
    bit on;
    k_tab = '{45, 93, 148, 215, 305, 443, 703, 1452};
    if (gx == 0 && gy == 0) return 0;
    ax = iabs(gx);
    ay = iabs(gy);
    if (ax == 0) begin
      a2 = 180;
    end else begin
      b = 0;
      on = (ay == 0);
      for (int i = 0; i < 8; i++) begin
        if (ay * 256 >= ax * k_tab[i]) begin
          b = i + 1;
          on = (ay * 256 == ax * k_tab[i]);
        end
      end
      a2 = on ? 20 * b : 20 * b + 10;
    end
    if (gx >= 0 && gy >= 0)     full = a2;
    else if (gx < 0 && gy >= 0) full = 360 - a2;
    else if (gx < 0)            full = 360 + a2;
    else                        full = 720 - a2;
    return (full % 720) / 20;
  endfunction

  function automatic logic [30:0] model_px(int x, int y);
    int mx, mn, c, v, gx, gy, mg;
    bit gt, lt, kpv;
    mx = 0; mn = 255; gt = 1'b1; lt = 1'b1;
    c = pix(x, y);
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        v = pix(x + dx, y + dy);
        if (v > mx) mx = v;
        if (v < mn) mn = v;
        if (dx != 0 || dy != 0) begin
          if (v >= c) gt = 1'b0;
          if (v <= c) lt = 1'b0;
        end
      end
    end
    kpv = gt || lt;
`ifdef SIFT_FEAT_CONTRAST_EN
    if (mx - mn < CTH) kpv = 1'b0;
`endif
    gx = pix(x + 1, y) - pix(x - 1, y);
    gy = pix(x, y + 1) - pix(x, y - 1);
    mg = (iabs(gx) + iabs(gy)) / 2;
    return {8'(mx), 8'(mn), kpv, 8'(mg), 6'(model_dir(gx, gy))};
  endfunction

  function automatic void fill_exp();
    exp_q.delete();
    for (int y = 1; y <= H - 2; y++)
      for (int x = 1; x <= W - 2; x++)
        exp_q.push_back(model_px(x, y));
  endfunction

  // scoreboard: compares every cycle once the first reset has been seen
  task automatic compare_cycle();
    logic [30:0] got, e;
    int idx;
    bit en_exp;
    got = {max_o, min_o, kp, mag, dir};
    if (rst_seen) begin
      check("reset addr", 64'(addr), 64'd0);
      check("reset outputs", 64'({got, out_en, c1, c2}), 64'd0);
      fill_exp();
      last_v = '0;
      pulses = 0;
    end else begin
      idx = rel - 3;
      en_exp = (idx >= 0) && (idx < N) && (idx % W >= 2) && (idx / W >= 2);
      check("addr", 64'(addr), 64'((rel < N - 1) ? rel : N - 1));
      check("complete1", 64'(c1), 64'(rel >= N));
      check("complete2", 64'(c2), 64'(rel >= N + 3));
      check("out_en", 64'(out_en), 64'(en_exp));
      if (out_en) pulses++;
      if (en_exp) begin
        if (exp_q.size() == 0) begin
          check("queue underrun", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("result(%0d,%0d)", idx % W - 1, idx / W - 1), 64'(got), 64'(e));
          last_v = e;
        end
      end else begin
        check("hold", 64'(got), 64'(last_v));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (active) compare_cycle();
  end

  // driver tasks
  task automatic load_image(input int kind);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (kind)
          0: img[y * W + x] = 8'h40;
          1: img[y * W + x] = 8'(4 * x);
          2: img[y * W + x] = 8'(4 * y);
          3: img[y * W + x] = 8'(255 - 4 * y);
          4: img[y * W + x] = (x == 3 && y == 3) ? 8'h80 : 8'h00;
          5: img[y * W + x] = 8'((x * x * 7 + y * 13 + x * y * 5) & 255);
          default: img[y * W + x] = (x == 4 && y == 4) ? 8'h10 : 8'h80;
        endcase
      end
    end
  endtask

  task automatic run_image(input int kind, input int mid_rst);
    bit done;
    load_image(kind);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    if (mid_rst > 0) begin
      repeat (mid_rst) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end
    done = 1'b0;
    for (int k = 0; k < N + 40 && !done; k++) begin
      @(negedge clk);
      #1;
      if (c2) done = 1'b1;
    end
    check("complete2 timeout", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("pulse count", 64'(pulses), 64'(NPULSE));
    check("queue drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) img[i] = 8'd0;

    // pin the orientation model with hand-worked angles
    check("pin dir 0deg",    64'(model_dir(8, 0)),    64'd0);
    check("pin dir 90deg",   64'(model_dir(0, 8)),    64'd9);
    check("pin dir 270deg",  64'(model_dir(0, -8)),   64'd27);
    check("pin dir 180deg",  64'(model_dir(-8, 0)),   64'd18);
    check("pin dir 45deg",   64'(model_dir(8, 8)),    64'd4);
    check("pin dir 225deg",  64'(model_dir(-8, -8)),  64'd22);
    check("pin dir 315deg",  64'(model_dir(8, -8)),   64'd31);
    check("pin dir zero",    64'(model_dir(0, 0)),    64'd0);
    check("pin dir 30 edge", 64'(model_dir(64, 37)),  64'd3);
    check("pin dir 150 edge", 64'(model_dir(-64, 37)), 64'd15);
    check("pin dir 330 edge", 64'(model_dir(64, -37)), 64'd33);

    // pin the window model on known images
    load_image(0);
    check("pin const", 64'(model_px(1, 1)), 64'({8'h40, 8'h40, 1'b0, 8'd0, 6'd0}));
    load_image(1);
    check("pin hramp", 64'(model_px(3, 3)), 64'({8'd16, 8'd8, 1'b0, 8'd4, 6'd0}));
    load_image(2);
    check("pin vramp", 64'(model_px(3, 3)), 64'({8'd16, 8'd8, 1'b0, 8'd4, 6'd9}));
    load_image(3);
    check("pin invramp", 64'(model_px(3, 3)), 64'({8'd247, 8'd239, 1'b0, 8'd4, 6'd27}));
    load_image(4);
    check("pin peak",  64'(model_px(3, 3)), 64'({8'h80, 8'h00, KP_SINGLE, 8'd0, 6'd0}));
    check("pin left",  64'(model_px(2, 3)), 64'({8'h80, 8'h00, 1'b0, 8'd64, 6'd0}));
    check("pin right", 64'(model_px(4, 3)), 64'({8'h80, 8'h00, 1'b0, 8'd64, 6'd18}));
    check("pin above", 64'(model_px(3, 2)), 64'({8'h80, 8'h00, 1'b0, 8'd64, 6'd9}));
    check("pin below", 64'(model_px(3, 4)), 64'({8'h80, 8'h00, 1'b0, 8'd64, 6'd27}));

    run_image(0, 0);
    run_image(1, 0);
    run_image(2, 0);
    run_image(3, 0);
    run_image(4, 0);
    run_image(5, 30);
    run_image(6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
